// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu32 between two requesters.
// Each granted operation is held on the ALU for EXEC_CYCLES, then captured and returned.
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [2:0]       req0_ctrl,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_out,
  output logic [2:0]       resp0_flags,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [2:0]       req1_ctrl,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_out,
  output logic [2:0]       resp1_flags,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_negative,
  output logic [1:0]       fsm_state
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic          cur_grant;
  logic          grant;
  logic          grant_any;
  logic          accept;
  logic          exec_done;
  logic          resp_fire;
  logic [CW-1:0] counter;

  // Handshakes: a transfer happens on the rising edge where valid && ready are both 1;
  // valid never waits on ready, and ready is only raised for the port that may transfer.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept)    state_next = S_EXEC;
      S_EXEC:  if (exec_done) state_next = S_RESP;
      S_RESP:  if (resp_fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Gating with reset keeps every handshake output low while reset is held,
  // including the cycle before the first edge has cleared the state register.
  always_comb begin
    req0_ready  = reset && (state == S_IDLE) && grant_any && !grant;
    req1_ready  = reset && (state == S_IDLE) && grant_any && grant;
    resp0_valid = reset && (state == S_RESP) && !cur_grant;
    resp1_valid = reset && (state == S_RESP) && cur_grant;
    accept      = reset && (state == S_IDLE) && grant_any;
    exec_done   = (state == S_EXEC) && (counter == LAST_COUNT);
    resp_fire   = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
    fsm_state   = state;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant  <= 1'b1;
      cur_grant   <= 1'b0;
      counter     <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_control <= '0;
      resp0_out   <= '0;
      resp0_flags <= '0;
      resp1_out   <= '0;
      resp1_flags <= '0;
    end else begin
      if (accept) begin
        alu_A       <= grant ? req1_A : req0_A;
        alu_B       <= grant ? req1_B : req0_B;
        alu_control <= grant ? req1_ctrl : req0_ctrl;
        cur_grant   <= grant;
        counter     <= '0;
      end
      if (state == S_EXEC) counter <= counter + CW'(1);
      // Flags come straight from the ALU; nothing is recomputed here.
      if (exec_done) begin
        if (cur_grant) begin
          resp1_out   <= alu_out;
          resp1_flags <= {alu_overflow, alu_zero, alu_negative};
        end else begin
          resp0_out   <= alu_out;
          resp0_flags <= {alu_overflow, alu_zero, alu_negative};
        end
      end
      if (resp_fire) last_grant <= cur_grant;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural alu32 on the ALU side.
// A second instance with EXEC_CYCLES=4 covers reset during a multi-cycle execute.
module tb_alu_arbiter;

  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b110;

  logic        clock;
  logic        reset;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_out, resp1_out, alu_A, alu_B, alu_out;
  logic [2:0]  resp0_flags, resp1_flags, alu_control;
  logic        alu_overflow, alu_zero, alu_negative;
  logic [1:0]  fsm_state;

  logic        d_req0_valid, d_req1_valid, d_resp0_ready, d_resp1_ready;
  logic [31:0] d_req0_A, d_req0_B, d_req1_A, d_req1_B;
  logic [2:0]  d_req0_ctrl, d_req1_ctrl;
  logic        d_req0_ready, d_req1_ready, d_resp0_valid, d_resp1_valid;
  logic [31:0] d_resp0_out, d_resp1_out, d_alu_A, d_alu_B, d_alu_out;
  logic [2:0]  d_resp0_flags, d_resp1_flags, d_alu_control;
  logic        d_alu_overflow, d_alu_zero, d_alu_negative;
  logic [1:0]  d_fsm_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [0:0]  port_q[$];

  // Behavioural alu32: {overflow, zero, negative, out}
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    logic [31:0] s;
    logic        v;
    s = 32'h0;
    v = 1'b0;
    case (c)
      ADD: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
      SUB: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
      3'b000: s = a & b;
      3'b001: s = a | b;
      default: s = 32'h0;
    endcase
    return {v, (s == 32'h0), s[31], s};
  endfunction

  assign {alu_overflow, alu_zero, alu_negative, alu_out} = alu_f(alu_A, alu_B, alu_control);
  assign {d_alu_overflow, d_alu_zero, d_alu_negative, d_alu_out} =
         alu_f(d_alu_A, d_alu_B, d_alu_control);

  alu_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) u_dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_ctrl(req0_ctrl), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_out(resp0_out), .resp0_flags(resp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_ctrl(req1_ctrl), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_out(resp1_out), .resp1_flags(resp1_flags),
    .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control), .alu_out(alu_out),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .fsm_state(fsm_state)
  );

  alu_arbiter #(.WIDTH(32), .EXEC_CYCLES(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .req0_valid(d_req0_valid), .req0_ready(d_req0_ready), .req0_A(d_req0_A), .req0_B(d_req0_B),
    .req0_ctrl(d_req0_ctrl), .resp0_valid(d_resp0_valid), .resp0_ready(d_resp0_ready),
    .resp0_out(d_resp0_out), .resp0_flags(d_resp0_flags),
    .req1_valid(d_req1_valid), .req1_ready(d_req1_ready), .req1_A(d_req1_A), .req1_B(d_req1_B),
    .req1_ctrl(d_req1_ctrl), .resp1_valid(d_resp1_valid), .resp1_ready(d_resp1_ready),
    .resp1_out(d_resp1_out), .resp1_flags(d_resp1_flags),
    .alu_A(d_alu_A), .alu_B(d_alu_B), .alu_control(d_alu_control), .alu_out(d_alu_out),
    .alu_overflow(d_alu_overflow), .alu_zero(d_alu_zero), .alu_negative(d_alu_negative),
    .fsm_state(d_fsm_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Driver: issue one op on port p of u_dut (called at posedge+1), returns what was seen.
  task automatic send_op(input bit p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, output bit granted, output int lat,
                         output logic [31:0] out, output logic [2:0] flags);
    bit seen;
    if (p) begin req1_valid = 1'b1; req1_A = a; req1_B = b; req1_ctrl = c; end
    else   begin req0_valid = 1'b1; req0_A = a; req0_B = b; req0_ctrl = c; end
    granted = 1'b0;
    lat = 0;
    out = 32'h0;
    flags = 3'h0;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clock);
      if (p ? req1_ready : req0_ready) granted = 1'b1;
    end
    @(posedge clock); #1;
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (granted) begin
      seen = 1'b0;
      for (int i = 1; i <= 30 && !seen; i++) begin
        @(negedge clock);
        if (p ? resp1_valid : resp0_valid) begin
          seen  = 1'b1;
          lat   = i;
          out   = p ? resp1_out : resp0_out;
          flags = p ? resp1_flags : resp0_flags;
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1; req0_A = 32'd5; req0_B = 32'd3; req0_ctrl = ADD;
    repeat (2) begin
      @(negedge clock);
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
      checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b%b want 00", resp0_valid, resp1_valid); end
      checks++; if (alu_A !== 32'h0 || alu_B !== 32'h0 || alu_control !== 3'h0) begin errors++; $display("FAIL reset_alu_regs: got %h %h %h want 0 0 0", alu_A, alu_B, alu_control); end
      checks++; if (resp0_out !== 32'h0 || resp0_flags !== 3'h0) begin errors++; $display("FAIL reset_resp0_data: got %h %b want 0", resp0_out, resp0_flags); end
      checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    end
    @(posedge clock); #1;
    reset = 1'b1;
    req0_valid = 1'b0;
  endtask

  task automatic test_single();
    bit g; int lat; logic [31:0] out; logic [2:0] fl;
    resp0_ready = 1'b1;
    send_op(1'b0, 32'd5, 32'd3, ADD, g, lat, out, fl);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL single_grant: got %b want 1", g); end
    checks++; if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", lat); end
    checks++; if (out !== 32'd8) begin errors++; $display("FAIL single_out: got %h want 8", out); end
    checks++; if (fl !== 3'b000) begin errors++; $display("FAIL single_flags: got %b want 000", fl); end
  endtask

  task automatic test_flags();
    bit g; int lat; logic [31:0] out; logic [2:0] fl;
    resp1_ready = 1'b1;
    send_op(1'b1, 32'h7FFF_FFFF, 32'h1, ADD, g, lat, out, fl);
    checks++; if (lat != 2) begin errors++; $display("FAIL ovf_latency: got %0d want 2", lat); end
    checks++; if (out !== 32'h8000_0000) begin errors++; $display("FAIL ovf_out: got %h want 80000000", out); end
    checks++; if (fl !== 3'b101) begin errors++; $display("FAIL ovf_flags: got %b want 101", fl); end
    send_op(1'b1, 32'd7, 32'd7, SUB, g, lat, out, fl);
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL zero_out: got %h want 0", out); end
    checks++; if (fl !== 3'b010) begin errors++; $display("FAIL zero_flags: got %b want 010", fl); end
    checks++; if (alu_A !== 32'd7 || alu_B !== 32'd7 || alu_control !== SUB) begin errors++; $display("FAIL idle_alu_hold: got %h %h %b want 7 7 110", alu_A, alu_B, alu_control); end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq;
    int ngrants, nresp;
    bit done;
    logic [0:0]  pexp;
    logic [31:0] oexp;
    seq = 4'h0; ngrants = 0; nresp = 0; done = 1'b0;
    reset = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_A = 32'd1;  req0_B = 32'd2; req0_ctrl = ADD;
    req1_valid = 1'b1; req1_A = 32'd10; req1_B = 32'd4; req1_ctrl = SUB;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clock);
      if (req0_ready && req1_ready) begin
        errors++; $display("FAIL rr_double_ready: got 11 want one-hot");
      end
      if (ngrants < 4 && (req0_ready || req1_ready)) begin
        seq[ngrants] = req1_ready;
        port_q.push_back(req1_ready);
        exp_q.push_back(req1_ready ? 32'd6 : 32'd3);
        ngrants++;
      end
      if (resp0_valid || resp1_valid) begin
        nresp++;
        pexp = port_q.pop_front();
        oexp = exp_q.pop_front();
        checks++;
        if ((resp0_valid && resp1_valid) || (resp1_valid !== pexp)) begin
          errors++; $display("FAIL rr_resp_port: got %b%b want port %0d", resp1_valid, resp0_valid, pexp);
        end
        checks++;
        if ((pexp ? resp1_out : resp0_out) !== oexp) begin
          errors++; $display("FAIL rr_resp_out: got %h want %h", pexp ? resp1_out : resp0_out, oexp);
        end
      end
      @(posedge clock); #1;
      if (ngrants == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (ngrants == 4 && port_q.size() == 0) done = 1'b1;
    end
    checks++; if (seq !== 4'b1010) begin errors++; $display("FAIL rr_grant_seq: got %b want 1010 (g3..g0)", seq); end
    checks++; if (nresp != 4) begin errors++; $display("FAIL rr_resp_count: got %0d want 4", nresp); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_resp_hold();
    bit hit;
    logic [31:0] held;
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_A = 32'd100; req0_B = 32'd23; req0_ctrl = ADD;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin @(negedge clock); hit = req0_ready; end
    checks++; if (!hit) begin errors++; $display("FAIL hold_grant0: got 0 want 1"); end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_A = 32'd9; req1_B = 32'd2; req1_ctrl = SUB;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin @(negedge clock); hit = resp0_valid; end
    checks++; if (!hit) begin errors++; $display("FAIL hold_resp0_seen: got 0 want 1"); end
    held = resp0_out;
    checks++; if (held !== 32'd123) begin errors++; $display("FAIL hold_out: got %h want 7b", held); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++; if (resp0_valid !== 1'b1 || resp0_out !== 32'd123 || resp0_flags !== 3'b000) begin errors++; $display("FAIL hold_stable: got %b %h %b want 1 7b 000", resp0_valid, resp0_out, resp0_flags); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL hold_req1_blocked: got %b want 0", req1_ready); end
    end
    @(posedge clock); #1;
    resp0_ready = 1'b1;
    @(posedge clock); #1;
    resp0_ready = 1'b0;
    @(negedge clock);
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL hold_resp0_drop: got %b want 0", resp0_valid); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold_req1_grant: got %b want 1", req1_ready); end
    @(posedge clock); #1;
    req1_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin @(negedge clock); hit = resp1_valid; end
    checks++; if (!hit || resp1_out !== 32'd7) begin errors++; $display("FAIL hold_resp1_out: got %b %h want 1 7", hit, resp1_out); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_exec();
    bit hit;
    int lat;
    d_resp0_ready = 1'b1;
    d_req0_valid = 1'b1; d_req0_A = 32'd20; d_req0_B = 32'd22; d_req0_ctrl = ADD;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin @(negedge clock); hit = d_req0_ready; end
    checks++; if (!hit) begin errors++; $display("FAIL rst_exec_grant: got 0 want 1"); end
    @(posedge clock); #1;
    d_req0_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (d_fsm_state !== 2'd1 || d_resp0_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_in_exec: got state %0d valid %b want 1 0", d_fsm_state, d_resp0_valid); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (d_fsm_state !== 2'd0) begin errors++; $display("FAIL rst_exec_state: got %0d want 0", d_fsm_state); end
    @(posedge clock); #1;
    reset = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (d_resp0_valid || d_resp1_valid) hit = 1'b1;
    end
    checks++; if (hit) begin errors++; $display("FAIL rst_exec_no_resp: got 1 want 0"); end
    @(posedge clock); #1;
    d_req0_valid = 1'b1; d_req0_A = 32'd40; d_req0_B = 32'd2; d_req0_ctrl = SUB;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin @(negedge clock); hit = d_req0_ready; end
    checks++; if (!hit) begin errors++; $display("FAIL rst_exec_regrant: got 0 want 1"); end
    @(posedge clock); #1;
    d_req0_valid = 1'b0;
    hit = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !hit; i++) begin
      @(negedge clock);
      if (d_resp0_valid) begin hit = 1'b1; lat = i; end
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL rst_exec_latency: got %0d want 5", lat); end
    checks++; if (d_resp0_out !== 32'd38 || d_resp0_flags !== 3'b000) begin errors++; $display("FAIL rst_exec_out: got %h %b want 26 000", d_resp0_out, d_resp0_flags); end
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_A = '0; req0_B = '0; req0_ctrl = '0; req1_A = '0; req1_B = '0; req1_ctrl = '0;
    d_req0_valid = 1'b0; d_req1_valid = 1'b0; d_resp0_ready = 1'b0; d_resp1_ready = 1'b1;
    d_req0_A = '0; d_req0_B = '0; d_req0_ctrl = '0; d_req1_A = '0; d_req1_B = '0; d_req1_ctrl = '0;
    test_reset();
    test_single();
    test_flags();
    test_round_robin();
    test_resp_hold();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
